// File: rtl/spi_write_arbiter.sv
// rtl/spi_write_arbiter.sv - arbitrates SPI-sourced and on-chip writes onto one register bank port
// SPI writes arrive as a toggle handshake from another clock domain; contested grants alternate.
module spi_write_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              iclk,
  input  logic              rstn,
  input  logic              spi_wr_toggle,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_data,
  input  logic              hw_wr_req,
  input  logic [ADDR_W-1:0] hw_addr,
  input  logic [DATA_W-1:0] hw_data,
  output logic              hw_wr_ack,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              busy,
  output logic              spi_overrun,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } state_t;

  localparam logic SRC_HW  = 1'b0;
  localparam logic SRC_SPI = 1'b1;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              sync3_q, sync3_d;
  logic              spi_pend_q, spi_pend_d;
  logic [ADDR_W-1:0] spi_addr_hold_q, spi_addr_hold_d;
  logic [DATA_W-1:0] spi_data_hold_q, spi_data_hold_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              src_q, src_d;
  logic              last_grant_q, last_grant_d;
  logic              overrun_q, overrun_d;
  logic              addr_err_q, addr_err_d;

  logic              spi_event;
  logic              grant_spi;
  logic              grant_hw;
  logic              contested;
  logic              addr_zero;

  always_comb begin
    sync1_d         = spi_wr_toggle;
    sync2_d         = sync1_q;
    sync3_d         = sync2_q;
    spi_event       = sync2_q ^ sync3_q;
    addr_zero       = (reg_addr_q == '0);

    state_d         = state_q;
    spi_pend_d      = spi_pend_q;
    spi_addr_hold_d = spi_addr_hold_q;
    spi_data_hold_d = spi_data_hold_q;
    reg_addr_d      = reg_addr_q;
    reg_wdata_d     = reg_wdata_q;
    src_d           = src_q;
    last_grant_d    = last_grant_q;
    overrun_d       = overrun_q;
    addr_err_d      = addr_err_q;

    contested = (state_q == IDLE) && spi_pend_q && hw_wr_req;
    grant_spi = 1'b0;
    grant_hw  = 1'b0;
    if (state_q == IDLE) begin
      if (contested) begin
        grant_spi = (last_grant_q == SRC_HW);
        grant_hw  = (last_grant_q == SRC_SPI);
      end else begin
        grant_spi = spi_pend_q;
        grant_hw  = hw_wr_req;
      end
    end

    case (state_q)
      IDLE:    if (grant_spi || grant_hw) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (grant_spi) begin
      reg_addr_d  = spi_addr_hold_q;
      reg_wdata_d = spi_data_hold_q;
      src_d       = SRC_SPI;
    end else if (grant_hw) begin
      reg_addr_d  = hw_addr;
      reg_wdata_d = hw_data;
      src_d       = SRC_HW;
    end

    // The round-robin pointer only moves when both sources competed.
    if (contested) last_grant_d = grant_spi ? SRC_SPI : SRC_HW;

    // A new event racing the grant refills the slot instead of counting as lost.
    if (spi_event) begin
      spi_pend_d      = 1'b1;
      spi_addr_hold_d = spi_addr;
      spi_data_hold_d = spi_data;
      if (spi_pend_q && !grant_spi) overrun_d = 1'b1;
    end else if (grant_spi) begin
      spi_pend_d = 1'b0;
    end

    if ((state_q == STROBE) && addr_zero) addr_err_d = 1'b1;
  end

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      sync1_q         <= 1'b0;
      sync2_q         <= 1'b0;
      sync3_q         <= 1'b0;
      spi_pend_q      <= 1'b0;
      spi_addr_hold_q <= '0;
      spi_data_hold_q <= '0;
      reg_addr_q      <= '0;
      reg_wdata_q     <= '0;
      src_q           <= SRC_HW;
      last_grant_q    <= SRC_HW;
      overrun_q       <= 1'b0;
      addr_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      sync3_q         <= sync3_d;
      spi_pend_q      <= spi_pend_d;
      spi_addr_hold_q <= spi_addr_hold_d;
      spi_data_hold_q <= spi_data_hold_d;
      reg_addr_q      <= reg_addr_d;
      reg_wdata_q     <= reg_wdata_d;
      src_q           <= src_d;
      last_grant_q    <= last_grant_d;
      overrun_q       <= overrun_d;
      addr_err_q      <= addr_err_d;
    end
  end

  // Address 0 is the pointer-set slot: the cycle still runs, only the strobe is dropped.
  assign reg_we      = (state_q == STROBE) && !addr_zero;
  assign hw_wr_ack   = (state_q == STROBE) && (src_q == SRC_HW);
  assign busy        = (state_q != IDLE);
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign spi_overrun = overrun_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_spi_write_arbiter.sv
// tb/tb_spi_write_arbiter.sv - scoreboard bench for spi_write_arbiter
// Stimulus pushes expected writes/acks; a negedge monitor pops and compares.
module tb_spi_write_arbiter;

  logic       iclk;
  logic       rstn;
  logic       spi_wr_toggle;
  logic [7:0] spi_addr;
  logic [7:0] spi_data;
  logic       hw_wr_req;
  logic [7:0] hw_addr;
  logic [7:0] hw_data;
  logic       hw_wr_ack;
  logic       reg_we;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       busy;
  logic       spi_overrun;
  logic       addr_err;

  int checks;
  int failures;
  int we_count;
  logic tog;
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_ack[$];
  logic [15:0] mon_wr;
  logic [7:0]  mon_ack;

  spi_write_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .iclk          (iclk),
    .rstn          (rstn),
    .spi_wr_toggle (spi_wr_toggle),
    .spi_addr      (spi_addr),
    .spi_data      (spi_data),
    .hw_wr_req     (hw_wr_req),
    .hw_addr       (hw_addr),
    .hw_data       (hw_data),
    .hw_wr_ack     (hw_wr_ack),
    .reg_we        (reg_we),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .busy          (busy),
    .spi_overrun   (spi_overrun),
    .addr_err      (addr_err)
  );

  initial begin
    iclk = 1'b0;
    forever #5 iclk = ~iclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor
  always @(negedge iclk) begin
    if (rstn) begin
      if (reg_we) begin
        we_count++;
        check("write_expected", {31'd0, exp_wr.size() != 0}, 32'd1);
        if (exp_wr.size() != 0) begin
          mon_wr = exp_wr.pop_front();
          check("write_addr_data", {16'd0, reg_addr, reg_wdata}, {16'd0, mon_wr});
        end
      end
      if (hw_wr_ack) begin
        check("ack_expected", {31'd0, exp_ack.size() != 0}, 32'd1);
        if (exp_ack.size() != 0) begin
          mon_ack = exp_ack.pop_front();
          check("ack_addr", {24'd0, reg_addr}, {24'd0, mon_ack});
        end
      end
    end
  end

  task automatic spi_send(input logic [7:0] a, input logic [7:0] d);
    spi_addr      = a;
    spi_data      = d;
    tog           = ~tog;
    spi_wr_toggle = tog;
  endtask

  task automatic hw_start(input logic [7:0] a, input logic [7:0] d);
    hw_addr   = a;
    hw_data   = d;
    hw_wr_req = 1'b1;
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    @(negedge iclk);
    while (!hw_wr_ack && n < 60) begin
      @(negedge iclk);
      n++;
    end
    check("ack_timeout", {31'd0, hw_wr_ack}, 32'd1);
  endtask

  task automatic hw_finish();
    wait_ack();
    @(posedge iclk);
    #1 hw_wr_req = 1'b0;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    repeat (5) @(posedge iclk);
    @(negedge iclk);
    while (busy && n < 60) begin
      @(negedge iclk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    @(posedge iclk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int we_before;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] b2b_a[3];
    logic [7:0] b2b_d[3];

    checks = 0; failures = 0; we_count = 0; tog = 1'b0;
    rstn = 1'b1; spi_wr_toggle = 1'b0; spi_addr = '0; spi_data = '0;
    hw_wr_req = 1'b0; hw_addr = '0; hw_data = '0;
    #2 rstn = 1'b0;
    repeat (2) @(posedge iclk);
    #1;
    check("rst_strobes", {29'd0, reg_we, hw_wr_ack, busy}, 32'd0);
    check("rst_regs", {16'd0, reg_addr, reg_wdata}, 32'd0);
    check("rst_sticky", {30'd0, spi_overrun, addr_err}, 32'd0);
    @(posedge iclk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge iclk);
    #1;

    // Single SPI write and its latency
    exp_wr.push_back({8'h05, 8'hA3});
    spi_send(8'h05, 8'hA3);
    n = 0;
    do begin
      @(posedge iclk);
      n++;
      @(negedge iclk);
    end while (!reg_we && n < 12);
    check("spi_latency", n, 32'd5);
    wait_quiet();

    // Tie after reset: SPI wins, then HW; second tie: HW wins
    for (int t = 0; t < 2; t++) begin
      if (t == 0) begin
        exp_wr.push_back({8'h10, 8'h11});
        exp_wr.push_back({8'h20, 8'h22});
      end else begin
        exp_wr.push_back({8'h20, 8'h22});
        exp_wr.push_back({8'h10, 8'h11});
      end
      exp_ack.push_back(8'h20);
      spi_send(8'h10, 8'h11);
      repeat (3) @(posedge iclk);
      #1 hw_start(8'h20, 8'h22);
      hw_finish();
      wait_quiet();
      check("tie_queue_drained", exp_wr.size(), 32'd0);
    end

    // Overrun: two toggles 2 cycles apart while a HW write occupies the port
    check("overrun_before", {31'd0, spi_overrun}, 32'd0);
    exp_wr.push_back({8'h40, 8'h44});
    exp_wr.push_back({8'h31, 8'h66});
    exp_ack.push_back(8'h40);
    spi_send(8'h30, 8'h55);
    repeat (2) @(posedge iclk);
    #1;
    spi_send(8'h31, 8'h66);
    hw_start(8'h40, 8'h44);
    hw_finish();
    wait_quiet();
    check("overrun_set", {31'd0, spi_overrun}, 32'd1);

    // Address 0 write is suppressed but still acknowledged
    check("addr_err_before", {31'd0, addr_err}, 32'd0);
    we_before = we_count;
    exp_ack.push_back(8'h00);
    hw_start(8'h00, 8'hFF);
    hw_finish();
    wait_quiet();
    check("addr0_no_we", we_count - we_before, 32'd0);
    check("addr_err_set", {31'd0, addr_err}, 32'd1);

    // Reset during SETUP aborts the write
    spi_send(8'h12, 8'h34);
    n = 0;
    do begin
      @(negedge iclk);
      n++;
    end while (!busy && n < 12);
    check("reach_setup", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    tog = 1'b0;
    spi_wr_toggle = 1'b0;
    #1;
    check("midrst_strobes", {29'd0, reg_we, hw_wr_ack, busy}, 32'd0);
    check("midrst_regs", {16'd0, reg_addr, reg_wdata}, 32'd0);
    check("midrst_sticky", {30'd0, spi_overrun, addr_err}, 32'd0);
    we_before = we_count;
    repeat (3) @(posedge iclk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge iclk);
    #1;
    exp_wr.push_back({8'h5A, 8'hC3});
    spi_send(8'h5A, 8'hC3);
    wait_quiet();
    repeat (4) @(posedge iclk);
    #1;
    check("post_reset_one_write", we_count - we_before, 32'd1);

    // Back-to-back HW writes: strobe every 3 cycles, one idle cycle between
    b2b_a[0] = 8'h61; b2b_a[1] = 8'h62; b2b_a[2] = 8'h63;
    b2b_d[0] = 8'h71; b2b_d[1] = 8'h72; b2b_d[2] = 8'h73;
    for (int w = 0; w < 3; w++) begin
      exp_wr.push_back({b2b_a[w], b2b_d[w]});
      exp_ack.push_back(b2b_a[w]);
    end
    hw_start(b2b_a[0], b2b_d[0]);
    wait_ack();
    for (int w = 1; w < 3; w++) begin
      @(posedge iclk);
      #1;
      hw_addr = b2b_a[w];
      hw_data = b2b_d[w];
      @(negedge iclk);
      check("b2b_gap_idle", {31'd0, busy}, 32'd0);
      @(negedge iclk);
      check("b2b_setup_busy", {31'd0, busy}, 32'd1);
      @(negedge iclk);
      check("b2b_strobe", {30'd0, reg_we, hw_wr_ack}, 32'd3);
    end
    @(posedge iclk);
    #1 hw_wr_req = 1'b0;
    wait_quiet();

    // Randomized serial traffic against the reference rule
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      d = 8'($urandom_range(0, 255));
      if (a != 8'h00) exp_wr.push_back({a, d});
      if ($urandom_range(0, 1) == 0) begin
        spi_send(a, d);
        wait_quiet();
      end else begin
        exp_ack.push_back(a);
        hw_start(a, d);
        hw_finish();
        wait_quiet();
      end
      repeat ($urandom_range(0, 3)) @(posedge iclk);
      #1;
    end

    repeat (4) @(posedge iclk);
    check("final_writes_drained", exp_wr.size(), 32'd0);
    check("final_acks_drained", exp_ack.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
